// File: rtl/avl_slave_mem.sv
// Avalon-MM slave backed by a 32-bit word memory with fixed (or, with
// AVL_SLAVE_MEM_RAND_WAIT_EN defined, LFSR-jittered) wait states.
module avl_slave_mem #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  input  logic        read,
  input  logic        write,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        protocol_err,
  output logic [1:0]  dbg_state
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  // Handshake: a request is accepted in IDLE when exactly one of read/write
  // is high; the master holds it until the cycle waitrequest is low (ACK).
  state_t                 state;
  logic [4:0]             cnt;
  logic                   lat_write;
  logic                   lat_in_range;
  logic [ADDR_BITS-1:0]   lat_idx;
  logic [3:0]             lat_be;
  logic [31:0]            lat_wdata;
  logic [31:0]            mem [DEPTH];

  logic [31:0]            offset;
  logic                   req_in_range;
  logic [ADDR_BITS-1:0]   req_idx;
  logic [4:0]             wait_cnt;
  logic                   accept;

  assign offset       = address - BASE_ADDR;
  assign req_in_range = (address >= BASE_ADDR) && ((offset >> (ADDR_BITS + 2)) == 32'd0);
  assign req_idx      = offset[ADDR_BITS+1:2];
  assign accept       = (state == IDLE) && (read ^ write);

`ifdef AVL_SLAVE_MEM_RAND_WAIT_EN
  logic [3:0] lfsr;

  assign wait_cnt = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};

  // x^4 + x^3 + 1, stepped once per accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 4'h1;
    end else if (accept) begin
      lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
    end
  end
`else
  assign wait_cnt = 5'(WAIT_CYCLES);
`endif

  always_comb begin
    waitrequest = 1'b0;
    if (state == IDLE) begin
      waitrequest = read ^ write;
    end else if (state == BUSY) begin
      waitrequest = read | write;
    end
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 5'd0;
      readdata     <= 32'd0;
      protocol_err <= 1'b0;
      lat_write    <= 1'b0;
      lat_in_range <= 1'b0;
      lat_idx      <= '0;
      lat_be       <= 4'd0;
      lat_wdata    <= 32'd0;
    end else begin
      protocol_err <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write    <= write;
            lat_in_range <= req_in_range;
            lat_idx      <= req_idx;
            lat_be       <= byteenable;
            lat_wdata    <= writedata;
            // Zero wait states skip BUSY so the read still completes in 2 cycles
            if (wait_cnt == 5'd0) begin
              state <= ACK;
              if (read) begin
                readdata <= req_in_range ? mem[req_idx] : 32'd0;
              end
            end else begin
              cnt   <= wait_cnt - 5'd1;
              state <= BUSY;
            end
          end else if (read && write) begin
            protocol_err <= 1'b1;
          end
        end
        BUSY: begin
          if (cnt == 5'd0) begin
            state <= ACK;
            if (!lat_write) begin
              readdata <= lat_in_range ? mem[lat_idx] : 32'd0;
            end
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is never cleared; a write lands only at the closing edge of ACK.
  always_ff @(posedge clk) begin
    if (!rst && state == ACK && lat_write && lat_in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (lat_be[b]) begin
          mem[lat_idx][8*b +: 8] <= lat_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule
